// File: rtl/bus1_pkg.sv
// Shared bus-1 definitions: command codes, bus widths and the frontend
// state type. Reused by the frontend, CPU model and cache model.
package bus1_pkg;

  localparam int unsigned BUS1_CMD_W   = 3;
  localparam int unsigned BUS1_ADDR_W  = 15;
  localparam int unsigned BUS1_OFF_W   = 4;
  localparam int unsigned BUS1_DATA_W  = 16;
  localparam int unsigned CORE_DATA_W  = 32;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_READ8   = 3'd1,
    CMD_READ16  = 3'd2,
    CMD_READ32  = 3'd3,
    CMD_INVAL   = 3'd4,
    CMD_WRITE8  = 3'd5,
    CMD_WRITE16 = 3'd6,
    CMD_WRITE32 = 3'd7
  } bus1_cmd_e;

  // RESPONSE shares code 7 with WRITE32; the driving side tells them apart.
  localparam logic [2:0] CMD_RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR2,
    ST_REQ,
    ST_WAIT_RESP,
    ST_RESP1,
    ST_RESP2,
    ST_TURN
  } bus1_state_e;

  function automatic logic bus1_is_read(input logic [2:0] cmd);
    return (cmd == CMD_READ8) || (cmd == CMD_READ16) || (cmd == CMD_READ32);
  endfunction

endpackage

// File: rtl/bus1_stats.sv
// Bus-1 frontend statistics: accepted-request and stall-cycle counters.
// Both wrap naturally at 2^32.
module bus1_stats
  import bus1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_fire,
  input  logic        i_stall,
  output logic [31:0] o_req_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [31:0] r_req_cnt;
  logic [31:0] r_stall_cnt;

  // Count accepted requests and cycles spent waiting on the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_req_fire) r_req_cnt   <= r_req_cnt + 32'd1;
      if (i_stall)    r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_req_cnt   = r_req_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/cache_bus1_frontend.sv
// Bus-1 to cache-core frontend: decodes the two-cycle CPU bus protocol into
// a single core request and returns the response over the shared bus.
// Optional statistics counters: define BUS1_FRONTEND_STATS_EN.
module cache_bus1_frontend
  import bus1_pkg::*;
#(
  parameter int unsigned ADDR1_W  = BUS1_ADDR_W,
  parameter int unsigned OFFSET_W = BUS1_OFF_W,
  parameter int unsigned DATA1_W  = BUS1_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          c1_in,
  output logic [2:0]          c1_out,
  output logic                c1_oe,
  input  logic [ADDR1_W-1:0]  a1_in,
  input  logic [DATA1_W-1:0]  d1_in,
  output logic [DATA1_W-1:0]  d1_out,
  output logic                d1_oe,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [2:0]          req_cmd,
  output logic [ADDR1_W-1:0]  req_tagset,
  output logic [OFFSET_W-1:0] req_offset,
  output logic [31:0]         req_wdata,
  input  logic                resp_valid,
  input  logic [31:0]         resp_rdata,
  output logic                proto_err,
  output logic [31:0]         stat_req_cnt,
  output logic [31:0]         stat_stall_cnt
);

  bus1_state_e         r_state;
  bus1_state_e         w_next;
  logic [2:0]          r_cmd;
  logic [ADDR1_W-1:0]  r_tagset;
  logic [OFFSET_W-1:0] r_offset;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_proto_err;
  logic [15:0]         w_d1_lo;
  logic [15:0]         w_resp_lo;

  assign w_d1_lo = 16'(d1_in);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (c1_in == CMD_INVAL)     w_next = ST_REQ;
        else if (c1_in != CMD_NOP)  w_next = ST_ADDR2;
      end
      ST_ADDR2:     w_next = ST_REQ;
      ST_REQ:       if (req_ready)  w_next = ST_WAIT_RESP;
      ST_WAIT_RESP: if (resp_valid) w_next = ST_RESP1;
      ST_RESP1:     w_next = (r_cmd == CMD_READ32) ? ST_RESP2 : ST_TURN;
      ST_RESP2:     w_next = ST_TURN;
      ST_TURN:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Request field capture, response capture and sticky protocol error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd       <= '0;
      r_tagset    <= '0;
      r_offset    <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (resp_valid && (r_state != ST_WAIT_RESP)) r_proto_err <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (c1_in != CMD_NOP) begin
            r_cmd    <= c1_in;
            r_tagset <= a1_in;
            r_wdata  <= {16'h0000, w_d1_lo};
            if (c1_in == CMD_INVAL) r_offset <= '0;
          end
        end
        ST_ADDR2: begin
          r_offset <= a1_in[OFFSET_W-1:0];
          if (r_cmd == CMD_WRITE32)     r_wdata[31:16] <= w_d1_lo;
          else if (r_cmd == CMD_WRITE8) r_wdata        <= {24'h000000, r_wdata[7:0]};
        end
        ST_WAIT_RESP: begin
          if (resp_valid) r_rdata <= resp_rdata;
        end
        default: ;
      endcase
    end
  end

  assign w_resp_lo = (r_cmd == CMD_READ8) ? {8'h00, r_rdata[7:0]} : r_rdata[15:0];

  // Bus and request outputs decoded from the current state
  always_comb begin
    c1_oe     = 1'b0;
    c1_out    = CMD_NOP;
    d1_oe     = 1'b0;
    d1_out    = '0;
    req_valid = 1'b0;
    unique case (r_state)
      ST_REQ: req_valid = 1'b1;
      ST_RESP1: begin
        c1_oe  = 1'b1;
        c1_out = CMD_RESPONSE;
        if (bus1_is_read(r_cmd)) begin
          d1_oe  = 1'b1;
          d1_out = DATA1_W'(w_resp_lo);
        end
      end
      ST_RESP2: begin
        c1_oe  = 1'b1;
        c1_out = CMD_RESPONSE;
        d1_oe  = 1'b1;
        d1_out = DATA1_W'(r_rdata[31:16]);
      end
      default: ;
    endcase
  end

  assign req_cmd    = r_cmd;
  assign req_tagset = r_tagset;
  assign req_offset = r_offset;
  assign req_wdata  = r_wdata;
  assign proto_err  = r_proto_err;

`ifdef BUS1_FRONTEND_STATS_EN
  logic w_req_fire;
  logic w_stall;

  assign w_req_fire = (r_state == ST_REQ) && req_ready;
  assign w_stall    = ((r_state == ST_REQ) && !req_ready) ||
                      ((r_state == ST_WAIT_RESP) && !resp_valid);

  bus1_stats u_stats (
    .clk         (clk),
    .rst         (reset),
    .i_req_fire  (w_req_fire),
    .i_stall     (w_stall),
    .o_req_cnt   (stat_req_cnt),
    .o_stall_cnt (stat_stall_cnt)
  );
`else
  assign stat_req_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_bus1_frontend.sv
// Directed self-checking bench for cache_bus1_frontend.
// Build with BUS1_FRONTEND_STATS_EN defined to check the counters.
module tb_cache_bus1_frontend;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  c1_in;
  logic [2:0]  c1_out;
  logic        c1_oe;
  logic [14:0] a1_in;
  logic [15:0] d1_in;
  logic [15:0] d1_out;
  logic        d1_oe;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [14:0] req_tagset;
  logic [3:0]  req_offset;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        proto_err;
  logic [31:0] stat_req_cnt;
  logic [31:0] stat_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

`ifdef BUS1_FRONTEND_STATS_EN
  localparam logic [31:0] EXP_STALL3 = 32'd3;
  localparam logic [31:0] EXP_REQ1   = 32'd1;
`else
  localparam logic [31:0] EXP_STALL3 = 32'd0;
  localparam logic [31:0] EXP_REQ1   = 32'd0;
`endif

  always #5 clk = ~clk;

  cache_bus1_frontend #(
    .ADDR1_W  (15),
    .OFFSET_W (4),
    .DATA1_W  (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .c1_in          (c1_in),
    .c1_out         (c1_out),
    .c1_oe          (c1_oe),
    .a1_in          (a1_in),
    .d1_in          (d1_in),
    .d1_out         (d1_out),
    .d1_oe          (d1_oe),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd        (req_cmd),
    .req_tagset     (req_tagset),
    .req_offset     (req_offset),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .proto_err      (proto_err),
    .stat_req_cnt   (stat_req_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Address cycle then second cycle; leaves the DUT in REQ with c1_in idle
  task automatic issue(input logic [2:0] cmd, input logic [14:0] a0, input logic [15:0] d0,
                       input logic [14:0] a1, input logic [15:0] d1, input logic [2:0] c_in_addr2);
    c1_in = cmd; a1_in = a0; d1_in = d0;
    tick();
    c1_in = c_in_addr2; a1_in = a1; d1_in = d1;
    tick();
    c1_in = 3'd0;
  endtask

  initial begin
    reset = 1'b1; c1_in = '0; a1_in = '0; d1_in = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    #3;
    chk("rst_c1_oe",     {31'd0, c1_oe}, 32'd0);
    chk("rst_c1_out",    {29'd0, c1_out}, 32'd0);
    chk("rst_d1_oe",     {31'd0, d1_oe}, 32'd0);
    chk("rst_d1_out",    {16'd0, d1_out}, 32'd0);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_tagset",    {17'd0, req_tagset}, 32'd0);
    chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
    chk("rst_stat_req",  stat_req_cnt, 32'd0);
    chk("rst_stat_stall", stat_stall_cnt, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // READ8, core ready immediately: RESP1 four edges after the address cycle
    req_ready = 1'b1;
    c1_in = 3'd1; a1_in = 15'h1A2B; d1_in = '0;
    tick();
    chk("r8_addr2_noreq", {31'd0, req_valid}, 32'd0);
    c1_in = 3'd0; a1_in = 15'd5;
    tick();
    chk("r8_req_valid", {31'd0, req_valid}, 32'd1);
    chk("r8_req_cmd",   {29'd0, req_cmd}, 32'd1);
    chk("r8_tagset",    {17'd0, req_tagset}, 32'h1A2B);
    chk("r8_offset",    {28'd0, req_offset}, 32'd5);
    tick();
    chk("r8_wait_noreq", {31'd0, req_valid}, 32'd0);
    resp_valid = 1'b1; resp_rdata = 32'h000000C3;
    tick();
    resp_valid = 1'b0;
    chk("r8_resp1_c1_oe",  {31'd0, c1_oe}, 32'd1);
    chk("r8_resp1_c1_out", {29'd0, c1_out}, 32'd7);
    chk("r8_resp1_d1_oe",  {31'd0, d1_oe}, 32'd1);
    chk("r8_resp1_d1_out", {16'd0, d1_out}, 32'h00C3);
    tick();
    chk("r8_turn_c1_oe", {31'd0, c1_oe}, 32'd0);
    chk("r8_turn_d1_oe", {31'd0, d1_oe}, 32'd0);
    tick();
    chk("r8_idle_c1_oe",  {31'd0, c1_oe}, 32'd0);
    chk("r8_idle_noreq",  {31'd0, req_valid}, 32'd0);
    chk("r8_proto_ok",    {31'd0, proto_err}, 32'd0);

    // READ8 zero-extension with noisy upper bytes
    issue(3'd1, 15'h0011, 16'h0, 15'd2, 16'h0, 3'd0);
    tick();
    resp_valid = 1'b1; resp_rdata = 32'hFFFF12C3;
    tick();
    resp_valid = 1'b0;
    chk("r8z_d1_out", {16'd0, d1_out}, 32'h00C3);
    tick(); tick();

    // READ32 returns two halves with RESPONSE on both cycles
    issue(3'd3, 15'h0222, 16'h0, 15'd4, 16'h0, 3'd0);
    tick();
    resp_valid = 1'b1; resp_rdata = 32'hDEADBEEF;
    tick();
    resp_valid = 1'b0;
    chk("r32_resp1_c1_out", {29'd0, c1_out}, 32'd7);
    chk("r32_resp1_d1_out", {16'd0, d1_out}, 32'hBEEF);
    tick();
    chk("r32_resp2_c1_oe",  {31'd0, c1_oe}, 32'd1);
    chk("r32_resp2_c1_out", {29'd0, c1_out}, 32'd7);
    chk("r32_resp2_d1_oe",  {31'd0, d1_oe}, 32'd1);
    chk("r32_resp2_d1_out", {16'd0, d1_out}, 32'hDEAD);
    tick();
    chk("r32_turn_c1_oe", {31'd0, c1_oe}, 32'd0);
    tick();

    // WRITE32 with a non-NOP command during the second cycle (not an error)
    issue(3'd7, 15'h0100, 16'h5678, 15'd3, 16'h1234, 3'd7);
    chk("w32_wdata",  req_wdata, 32'h12345678);
    chk("w32_cmd",    {29'd0, req_cmd}, 32'd7);
    chk("w32_offset", {28'd0, req_offset}, 32'd3);
    tick();
    resp_valid = 1'b1; resp_rdata = 32'hAAAA5555;
    tick();
    resp_valid = 1'b0;
    chk("w32_resp1_c1_oe", {31'd0, c1_oe}, 32'd1);
    chk("w32_resp1_d1_oe", {31'd0, d1_oe}, 32'd0);
    tick();
    chk("w32_turn_c1_oe", {31'd0, c1_oe}, 32'd0);
    tick();
    chk("w32_proto_ok", {31'd0, proto_err}, 32'd0);

    // WRITE8 keeps only the low byte
    issue(3'd5, 15'h0033, 16'hABCD, 15'd1, 16'hFFFF, 3'd0);
    chk("w8_wdata", req_wdata, 32'h000000CD);
    tick();
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    tick(); tick();

    // INVALIDATE_LINE goes straight to REQ with offset cleared
    c1_in = 3'd4; a1_in = 15'h0040; d1_in = '0;
    tick();
    c1_in = 3'd0;
    chk("inv_req_valid", {31'd0, req_valid}, 32'd1);
    chk("inv_tagset",    {17'd0, req_tagset}, 32'h0040);
    chk("inv_offset",    {28'd0, req_offset}, 32'd0);
    tick();
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    chk("inv_resp1_d1_oe", {31'd0, d1_oe}, 32'd0);
    tick(); tick();

    // Core stalls REQ for three cycles; fields must hold
    do_reset();
    req_ready = 1'b0;
    issue(3'd2, 15'h2222, 16'h0, 15'd9, 16'h0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req_valid", {31'd0, req_valid}, 32'd1);
      chk("stall_tagset",    {17'd0, req_tagset}, 32'h2222);
      chk("stall_offset",    {28'd0, req_offset}, 32'd9);
      a1_in = 15'h7FFF;
      tick();
    end
    chk("stall_still_req", {31'd0, req_valid}, 32'd1);
    req_ready = 1'b1;
    tick();
    resp_valid = 1'b1; resp_rdata = 32'h00005A5A;
    chk("stall_cnt", stat_stall_cnt, EXP_STALL3);
    tick();
    resp_valid = 1'b0;
    chk("stall_resp1_d1_out", {16'd0, d1_out}, 32'h5A5A);
    chk("stall_cnt_hold", stat_stall_cnt, EXP_STALL3);
    chk("req_cnt",        stat_req_cnt, EXP_REQ1);
    tick(); tick();

    // Reset in WAIT_RESP aborts; a late response is a protocol error
    issue(3'd2, 15'h0777, 16'h0, 15'd6, 16'h0, 3'd0);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("abort_c1_oe",     {31'd0, c1_oe}, 32'd0);
    chk("abort_d1_oe",     {31'd0, d1_oe}, 32'd0);
    chk("abort_req_valid", {31'd0, req_valid}, 32'd0);
    chk("abort_tagset",    {17'd0, req_tagset}, 32'd0);
    chk("abort_stall_cnt", stat_stall_cnt, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_no_replay", {31'd0, req_valid}, 32'd0);
    chk("abort_proto_clr", {31'd0, proto_err}, 32'd0);
    resp_valid = 1'b1; resp_rdata = 32'h11112222;
    tick();
    resp_valid = 1'b0;
    chk("stray_proto_err", {31'd0, proto_err}, 32'd1);
    chk("stray_no_resp",   {31'd0, c1_oe}, 32'd0);
    tick();
    chk("stray_sticky", {31'd0, proto_err}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_bus1_frontend.md
CACHE_BUS1_FRONTEND -- requirements
Module: cache_bus1_frontend

Interface
REQ-001 Parameter ADDR1_W, default 15, tag+set field width carried on bus-1 address lines.
REQ-002 Parameter OFFSET_W, default 4, byte offset width within a cache line.
REQ-003 Parameter DATA1_W, default 16, bus-1 data width.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Ports c1_in/c1_out/c1_oe  in/out/out  3/3/1  bus-1 command lines, split tri-state; c1_oe=1 means the frontend drives.
REQ-007 Ports a1_in  input  ADDR1_W  bus-1 address lines, driven by the CPU.
REQ-008 Ports d1_in/d1_out/d1_oe  in/out/out  DATA1_W/DATA1_W/1  bus-1 data lines, split tri-state.
REQ-009 Ports req_valid/req_ready  out/in  1/1  request handshake to the cache core.
REQ-010 Ports req_cmd/req_tagset/req_offset/req_wdata  out  3/ADDR1_W/OFFSET_W/32  captured request fields.
REQ-011 Ports resp_valid/resp_rdata  in  1/32  core completion pulse and read data.
REQ-012 Ports proto_err  out  1  sticky protocol-violation flag.
REQ-013 Ports stat_req_cnt/stat_stall_cnt  out  32/32  statistics counters (see Configuration).

Function
REQ-014 Command codes SHALL be NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7, RESPONSE=7 (CPU-driven vs frontend-driven direction distinguishes 7).
REQ-015 States: IDLE, ADDR2, REQ, WAIT_RESP, RESP1, RESP2, TURN.
REQ-016 IDLE: c1_in=NOP -> stay; any other code -> latch cmd, tagset=a1_in, wdata[15:0]=d1_in; INVALIDATE_LINE -> REQ (offset=0), else -> ADDR2.
REQ-017 ADDR2: latch offset=a1_in[OFFSET_W-1:0]; WRITE32 also latches wdata[31:16]=d1_in; WRITE8 masks wdata to [7:0]; -> REQ.
REQ-018 REQ: req_valid=1 with stable fields until the edge where req_ready=1 -> WAIT_RESP.
REQ-019 WAIT_RESP: resp_valid=1 -> latch resp_rdata -> RESP1.
REQ-020 RESP1: c1_oe=1, c1_out=RESPONSE; reads drive d1_oe=1 with d1_out=rdata[15:0] (READ8 zero-extends [7:0]); writes/invalidate d1_oe=0; READ32 -> RESP2, else -> TURN.
REQ-021 RESP2: c1_out=RESPONSE, d1_out=rdata[31:16] -> TURN.
REQ-022 TURN: c1_oe=0, d1_oe=0 for exactly one cycle (bus hand-back) -> IDLE; c1_in ignored.
REQ-023 Minimum latency, first address cycle to RESP1 = 4 cycles (req_ready and resp_valid both asserted on first opportunity).
REQ-024 resp_valid outside WAIT_RESP SHALL be ignored and set proto_err; c1_in!=NOP in ADDR2 is not an error.
REQ-025 req_valid SHALL never deassert without req_ready; at most one request outstanding.

Reset
REQ-026 reset SHALL force IDLE, c1_oe=d1_oe=req_valid=0, c1_out=NOP, d1_out=0, latched fields=0, proto_err=0, counters=0, including mid-transaction; the aborted request is not replayed.

Configuration
REQ-027 With BUS1_FRONTEND_STATS_EN defined: stat_req_cnt increments on each REQ->WAIT_RESP transition; stat_stall_cnt increments per cycle in REQ with req_ready=0 or in WAIT_RESP with resp_valid=0; both wrap at 2^32.
REQ-028 Without BUS1_FRONTEND_STATS_EN: both stat ports tied to 0, no counter flops.

Structure
REQ-029 Shared package bus1_pkg SHALL hold the command enum, bus widths, and state typedef; the same package is reused by the CPU and cache models.
REQ-030 Counters SHALL live in one sub-module bus1_stats, instantiated only under the macro.

Verification
REQ-031 READ8 tagset=0x1A2B, offset=5, core ready immediately, rdata=0x000000C3 -> RESP1 d1_out=0x00C3, then TURN, IDLE.
REQ-032 READ32 rdata=0xDEADBEEF -> RESP1 d1_out=0xBEEF, RESP2 d1_out=0xDEAD, c1_out=7 both cycles.
REQ-033 WRITE32 d1=0x5678 then 0x1234 -> req_wdata=0x12345678, RESP1 with d1_oe=0.
REQ-034 INVALIDATE_LINE tagset=0x0040 -> req_valid on the next cycle, offset=0, no ADDR2 state.
REQ-035 req_ready held 0 for 3 cycles -> fields stable, stat_stall_cnt=3 (macro on) or 0 (off).
REQ-036 reset asserted in WAIT_RESP -> immediate IDLE, oe=0; stray resp_valid afterwards -> proto_err=1.
